// File: rtl/vit213_sched_pkg.sv
// Shared definitions for the (2,1,3) Viterbi frame scheduler.
//   state_t : scheduler FSM states (3-bit encoding, IDLE=0 .. DONE=4)
//   N_SYM   : encoded symbol width fed to the decoder Rx input
//   N_CH    : number of requesting symbol channels
package vit213_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int N_SYM = 2;
    localparam int N_CH  = 2;

endpackage

// File: rtl/vit213_rr_arb2.sv
// Two-requester round-robin grant, purely combinational.
//   valid     : request vector, bit N = channel N
//   last      : channel served by the previous frame (register lives in parent)
//   grant     : winning channel index
//   grant_any : at least one request present
module vit213_rr_arb2
    import vit213_sched_pkg::*;
(
    input  logic [N_CH-1:0] valid,
    input  logic            last,
    output logic            grant,
    output logic            grant_any
);

    always_comb begin
        grant_any = |valid;
        // On a tie the channel not served last wins; otherwise the lone requester.
        if (&valid) grant = ~last;
        else        grant = valid[1];
    end

endmodule

// File: rtl/vit213_frame_sched.sv
// Frame scheduler sharing one Viterbi decoder between two symbol channels.
// A whole frame is granted to one channel (round-robin), its FRAME_LEN symbols
// are streamed into the decoder and OUT_LEN decoded bits are collected and
// tagged with the channel.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   reqN_valid/sym/ready    : per-channel symbol stream (N = 0, 1)
//   dec_Rx, dec_seq_ready   : symbol and sequence-start pulse to the decoder
//   dec_Dx, dec_oe          : decoded bit and its strobe from the decoder
//   dec_sync_error          : decoder sync loss, makes the frame fail
//   out_valid/bit/ch/last   : decoded bit stream, one cycle after dec_oe
//   frame_done, frame_err   : end-of-frame pulse and its status
//   busy                    : scheduler not idle
module vit213_frame_sched
    import vit213_sched_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int OUT_LEN   = 61,
    parameter int TIMEOUT   = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [N_SYM-1:0] req0_sym,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N_SYM-1:0] req1_sym,
    output logic             req1_ready,
    output logic [N_SYM-1:0] dec_Rx,
    output logic             dec_seq_ready,
    input  logic             dec_Dx,
    input  logic             dec_oe,
    input  logic             dec_sync_error,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_ch,
    output logic             out_last,
    output logic             frame_done,
    output logic             frame_err,
    output logic             busy
);

    localparam int SCW = $clog2(FRAME_LEN + 1);
    localparam int OCW = $clog2(OUT_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [SCW-1:0] SCNT_LAST = SCW'(FRAME_LEN - 1);
    localparam logic [SCW-1:0] SCNT_TERM = SCW'(FRAME_LEN);
    localparam logic [OCW-1:0] OCNT_LAST = OCW'(OUT_LEN - 1);
    localparam logic [OCW-1:0] OCNT_TERM = OCW'(OUT_LEN);
    localparam logic [TCW-1:0] TCNT_LAST = TCW'(TIMEOUT - 1);
    localparam logic [TCW-1:0] TCNT_TERM = TCW'(TIMEOUT);

    state_t         state;
    logic           grant;
    logic           last;
    logic           err;
    logic [SCW-1:0] scnt;
    logic [OCW-1:0] ocnt;
    logic [TCW-1:0] tcnt;

    logic             arb_grant;
    logic             arb_any;
    logic             in_feed;
    logic             in_drain;
    logic             active;
    logic             g_valid;
    logic [N_SYM-1:0] g_sym;
    logic             xfer;
    logic             capture;
    logic             ocnt_hit;
    logic             out_done;
    logic             tcnt_hit;

    vit213_rr_arb2 u_arb (
        .valid     ({req1_valid, req0_valid}),
        .last      (last),
        .grant     (arb_grant),
        .grant_any (arb_any)
    );

    assign in_feed  = (state == ST_FEED);
    assign in_drain = (state == ST_DRAIN);
    assign active   = in_feed | in_drain;
    assign g_valid  = grant ? req1_valid : req0_valid;
    assign g_sym    = grant ? req1_sym   : req0_sym;
    assign xfer     = in_feed & g_valid;

    // Decoded bits are only taken while a frame owns the decoder; the count
    // saturates at OUT_LEN so stray strobes cannot wrap it.
    assign capture  = active & dec_oe & (ocnt != OCNT_TERM);
    assign ocnt_hit = capture & (ocnt == OCNT_LAST);
    // OUT_LEN may already be reached during FEED, then DRAIN ends at once.
    assign out_done = ocnt_hit | (ocnt == OCNT_TERM);
    // This DRAIN cycle is the one that brings the timeout count to TIMEOUT.
    assign tcnt_hit = (tcnt == TCNT_LAST);

    // Moore outputs decoded straight from the state register.
    assign req0_ready    = in_feed & ~grant;
    assign req1_ready    = in_feed &  grant;
    assign dec_seq_ready = (state == ST_ARM);
    assign busy          = (state != ST_IDLE);
    assign frame_done    = (state == ST_DONE);
    assign frame_err     = frame_done & err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant     <= 1'b0;
            last      <= 1'b1;
            err       <= 1'b0;
            scnt      <= '0;
            ocnt      <= '0;
            tcnt      <= '0;
            dec_Rx    <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_ch    <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // Rx carries the accepted symbol for exactly one cycle, else 0.
            dec_Rx    <= xfer ? g_sym : '0;
            out_valid <= capture;
            out_bit   <= capture & dec_Dx;
            out_ch    <= capture & grant;
            out_last  <= ocnt_hit;

            if (capture)                  ocnt <= ocnt + 1'b1;
            if (active && dec_sync_error) err  <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant <= arb_grant;
                        state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    scnt  <= '0;
                    ocnt  <= '0;
                    tcnt  <= '0;
                    err   <= 1'b0;
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    if (!g_valid) begin
                        // Requester must stream back to back; a gap aborts.
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        if (scnt != SCNT_TERM) scnt <= scnt + 1'b1;
                        if (scnt == SCNT_LAST) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (tcnt != TCNT_TERM) tcnt <= tcnt + 1'b1;
                    // Final bit in the timeout cycle counts as success.
                    if (out_done) begin
                        state <= ST_DONE;
                    end else if (tcnt_hit) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last  <= grant;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vit213_frame_sched.md
# vit213_frame_sched

Frame scheduler that shares one (2,1,3) Viterbi decoder between two symbol-stream requesters. It grants the decoder to one requester for a whole frame, round-robin. It issues the decoder's per-sequence start (`seq_ready`), streams that requester's `FRAME_LEN` encoded symbols into `Rx`, and collects `OUT_LEN` decoded bits from `Dx`/`oe`, tagged with the channel. It sits between the channel front-ends and the decoder top, and reports per-frame errors from input underrun, decoder sync error or output timeout.

## Interface
- `FRAME_LEN`, 64: encoded 2-bit symbols per frame, including tail; must be ≥ 4.
- `OUT_LEN`, 61: decoded bits expected per frame; must be in 1..FRAME_LEN.
- `TIMEOUT`, 256: maximum cycles in DRAIN before the frame is abandoned.
- `clock  in  1`: single clock; all logic on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `req0_valid  in  1`: channel 0 symbol valid.
- `req0_sym  in  2`: channel 0 encoded symbol.
- `req0_ready  out  1`: channel 0 symbol accepted.
- `req1_valid`, `req1_sym`, `req1_ready`: same as channel 0, for channel 1.
- `dec_Rx  out  2`: symbol to the decoder `Rx`.
- `dec_seq_ready  out  1`: one-cycle sequence-start pulse to the decoder.
- `dec_Dx  in  1`: decoder `Dx`.
- `dec_oe  in  1`: decoder `oe`.
- `dec_sync_error  in  1`: decoder `sync_error`.
- `out_valid  out  1`: decoded bit valid.
- `out_bit  out  1`: decoded bit.
- `out_ch  out  1`: channel the decoded bit belongs to.
- `out_last  out  1`: marks the final (`OUT_LEN`-th) bit of the frame.
- `frame_done  out  1`: one-cycle pulse at frame end.
- `frame_err  out  1`: valid with `frame_done`; 1 = frame failed.
- `busy  out  1`: high in every state except IDLE.

## Operation
- FSM states: IDLE, ARM, FEED, DRAIN, DONE.
- **IDLE → ARM** when any `reqN_valid` is high.
  - The grant is latched in this cycle.
  - Round-robin: if both channels are valid, grant the channel not served last.
  - After reset, the last-served pointer is 1, so channel 0 wins the first tie.
- **ARM** (one cycle): `dec_seq_ready` = 1. Clear the symbol counter, output counter, error flag and timeout counter.
- **FEED**:
  - `reqG_ready` = 1 for the granted channel only.
  - On a transfer (valid & ready), register the symbol into `dec_Rx` and increment the symbol counter.
  - On the `FRAME_LEN`-th transfer → DRAIN.
  - If `reqG_valid` is low in any FEED cycle (underrun): set the error flag and go to DONE. The requester must stream contiguously.
- **DRAIN**:
  - `dec_Rx` = 0 and both ready outputs = 0.
  - The timeout counter increments each cycle.
  - Exit to DONE on the `OUT_LEN`-th `dec_oe`.
  - Exit to DONE with error when the timeout counter reaches `TIMEOUT`.
- **Decoded-bit capture, FEED and DRAIN only**:
  - Each `dec_oe` produces a registered `out_valid` with `out_bit` = `dec_Dx` and `out_ch` = grant, and increments the output counter.
  - `out_last` is asserted on the bit that makes the counter equal `OUT_LEN`.
  - `dec_oe` in IDLE, ARM or DONE is ignored. `dec_oe` beyond `OUT_LEN` cannot occur, because DRAIN exits.
- `dec_sync_error` high in any FEED or DRAIN cycle sets the sticky error flag; the frame still runs to completion.
- **DONE** (one cycle):
  - `frame_done` = 1 and `frame_err` = error flag.
  - Update the last-served pointer to the grant.
  - → IDLE.
- **Simultaneous events**:
  - The `OUT_LEN`-th `oe` in the timeout cycle: success wins, no error.
  - Underrun in the same cycle as `sync_error`: one error, reported once.
- **Reset mid-frame**: all registers return to their reset values, the FSM goes to IDLE and the partial frame is dropped. No `frame_done` is produced.
- **Width rules**:
  - Symbol counter is `$clog2(FRAME_LEN+1)` bits.
  - Output counter is `$clog2(OUT_LEN+1)` bits.
  - Timeout counter is `$clog2(TIMEOUT+1)` bits.
  - All counters are unsigned with no wrap: each is cleared in ARM and stops at its terminal value.

## Timing
- **Reset values**: every output is 0, the FSM is in IDLE and the last-served pointer is 1.
- **Grant latency**: valid seen in IDLE at cycle t → ARM at t+1 (`seq_ready`) → FEED from t+2, with ready high from t+2.
- `dec_Rx` lags the accepted symbol by one cycle, so the first symbol reaches the decoder at t+3.
- Minimum FEED length is `FRAME_LEN` cycles.
- `out_*` lag `dec_oe` by one cycle.
- `frame_done` comes one cycle after the exit condition.
- A new frame can start arbitration the cycle after DONE, giving 2 dead cycles between frames.

## Structure
- **Shared package `vit213_sched_pkg`**:
  - State enum (IDLE=0, ARM=1, FEED=2, DRAIN=3, DONE=4; 3 bits).
  - Symbol width `N_SYM`=2.
  - Channel count 2.
- **Sub-module `vit213_rr_arb2`**: a 2-requester round-robin grant.
  - Inputs: valids, last-served pointer.
  - Outputs: grant index, grant-any.
  - Combinational; the pointer register lives in the parent.

## Test plan
- **Single frame**: ch0 streams 64 contiguous symbols; model `oe` with 61 pulses during FEED/DRAIN → `seq_ready` pulse at t+1; 64 ready cycles; 61 `out_valid` with `out_ch`=0; `out_last` on the 61st; `frame_done`=1, `frame_err`=0.
- **Fairness**: both channels valid continuously for 4 frames → grants 0,1,0,1; the other channel's ready stays 0 throughout.
- **Underrun**: ch1 drops valid after 10 symbols → DONE with `frame_err`=1 two cycles later; no further ready; `busy` falls.
- **Sync error / timeout**: pulse `dec_sync_error` once mid-FEED → frame completes with `frame_err`=1. Separately, stop `oe` after 30 bits → `frame_err`=1 exactly `TIMEOUT` cycles after DRAIN entry.
- **Reset mid-DRAIN** → next cycle all outputs 0, state IDLE; a subsequent tie grants ch0 first.
- **Boundary**: 61st `oe` in the same cycle the timeout counter hits `TIMEOUT` → `frame_err`=0, `out_last`=1.
